// File: rtl/pairing_result_uart_tx.sv
// Captures a DATA_W-bit word and transmits it as back-to-back 8N1 UART frames,
// one byte per frame, LSB of each byte first. Byte order is selected by MSB_FIRST.
module pairing_result_uart_tx #(
    parameter int unsigned DATA_W    = 304,
    parameter int unsigned CLK_DIV   = 868,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic              uart_txd
);

    localparam int unsigned NBYTES = (DATA_W + 7) / 8;
    localparam int unsigned SR_W   = NBYTES * 8;
    localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BC_W   = $clog2(NBYTES + 1);

    localparam logic [CNT_W-1:0] CntLast  = CNT_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0]  ByteLast = BC_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [7:0] cur_byte;
    logic [2:0] nxt_bit;

    // The byte in flight always sits at the end of the shift register that leaves first.
    assign cur_byte = MSB_FIRST ? sr_q[SR_W-1 -: 8] : sr_q[7:0];
    assign nxt_bit  = bit_cnt_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (load) begin
                    sr_d       = SR_W'(din);
                    state_d    = StStart;
                    cnt_d      = '0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            StStart: begin
                if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StData;
                    txd_d     = cur_byte[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                        txd_d   = 1'b1;
                    end else begin
                        bit_cnt_d = nxt_bit;
                        txd_d     = cur_byte[nxt_bit];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d      = '0;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    sr_d       = MSB_FIRST ? (sr_q << 8) : (sr_q >> 8);
                    if (byte_cnt_q == ByteLast) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        txd_d   = 1'b1;
                    end else begin
                        state_d = StStart;
                        txd_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                txd_d   = 1'b1;
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            sr_q       <= '0;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign uart_txd = txd_q;

endmodule

// File: tb/tb_pairing_result_uart_tx.sv
// Bench for pairing_result_uart_tx: four configurations share one clock and reset;
// directed vectors give the expected transmitted byte sequence for each frame.
module tb_pairing_result_uart_tx;

    logic         clk;
    logic         rstn;
    logic [3:0]   load_v;
    logic [303:0] din_v;
    int           sel;

    logic [3:0] busy_v, done_v, txd_v;
    logic       busy_m, done_m, txd_m;

    int checks = 0;
    int errors = 0;

    pairing_result_uart_tx #(.DATA_W(16), .CLK_DIV(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rstn(rstn), .load(load_v[0]), .din(din_v[15:0]),
        .busy(busy_v[0]), .done(done_v[0]), .uart_txd(txd_v[0])
    );
    pairing_result_uart_tx #(.DATA_W(16), .CLK_DIV(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rstn(rstn), .load(load_v[1]), .din(din_v[15:0]),
        .busy(busy_v[1]), .done(done_v[1]), .uart_txd(txd_v[1])
    );
    pairing_result_uart_tx #(.DATA_W(12), .CLK_DIV(4), .MSB_FIRST(1'b0)) u_w12 (
        .clk(clk), .rstn(rstn), .load(load_v[2]), .din(din_v[11:0]),
        .busy(busy_v[2]), .done(done_v[2]), .uart_txd(txd_v[2])
    );
    pairing_result_uart_tx #(.DATA_W(304), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_big (
        .clk(clk), .rstn(rstn), .load(load_v[3]), .din(din_v),
        .busy(busy_v[3]), .done(done_v[3]), .uart_txd(txd_v[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        busy_m = busy_v[sel];
        done_m = done_v[sel];
        txd_m  = txd_v[sel];
    end

    // exp holds the bytes in transmission order: exp[7:0] leaves first.
    typedef struct {
        int           sel;
        int           nbytes;
        int           div;
        logic [303:0] din;
        logic [303:0] exp;
        int           extra_load;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic logic exp_txd(input int v, input int c);
        int slot, k, s;
        slot = (c - 1) / vecs[v].div;
        k    = slot / 10;
        s    = slot % 10;
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return vecs[v].exp[8 * k + s - 1];
    endfunction

    // Caller sits at a negedge; returns at the negedge after the done cycle.
    task automatic run_frame(input int v, input string tag);
        int n, bad_t, bad_b, bad_d;
        n = vecs[v].nbytes * 10 * vecs[v].div;
        bad_t = 0; bad_b = 0; bad_d = 0;
        sel = vecs[v].sel;
        din_v = vecs[v].din;
        load_v[sel] = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= n; c++) begin
            load_v = '0;
            if (txd_m !== exp_txd(v, c)) bad_t++;
            if (busy_m !== 1'b1) bad_b++;
            if (done_m !== 1'b0) bad_d++;
            if (c == vecs[v].extra_load) begin
                load_v[sel] = 1'b1;
                din_v = '0;
            end
            @(negedge clk);
        end
        load_v = '0;
        check({tag, "_txd_bad_cycles"}, bad_t, 0);
        check({tag, "_busy_bad_cycles"}, bad_b, 0);
        check({tag, "_early_done_cycles"}, bad_d, 0);
        check({tag, "_done_pulse"}, done_m, 1);
        check({tag, "_busy_at_done"}, busy_m, 0);
        check({tag, "_txd_at_done"}, txd_m, 1);
        @(negedge clk);
        check({tag, "_done_cleared"}, done_m, 0);
        check({tag, "_idle_txd"}, txd_m, 1);
    endtask

    initial begin
        int bad, got;
        logic [303:0] rnd;

        vecs[0] = '{sel: 0, nbytes: 2, div: 4, din: 304'hA55A, exp: 304'hA55A, extra_load: 0};
        vecs[1] = '{sel: 1, nbytes: 2, div: 4, din: 304'hA55A, exp: 304'h5AA5, extra_load: 0};
        vecs[2] = '{sel: 2, nbytes: 2, div: 4, din: 304'hFFFF, exp: 304'h0FFF, extra_load: 0};
        vecs[3] = '{sel: 0, nbytes: 2, div: 4, din: 304'hA55A, exp: 304'hA55A, extra_load: 10};
        rnd = '0;
        for (int i = 0; i < 10; i++) rnd[32 * i +: 32] = $urandom;
        rnd[303:0] = rnd[303:0];
        vecs[4] = '{sel: 3, nbytes: 38, div: 2, din: rnd, exp: rnd, extra_load: 0};

        sel = 0;
        rstn = 1'b0;
        load_v = '0;
        din_v = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            check("reset_busy", busy_v[s], 0);
            check("reset_done", done_v[s], 0);
            check("reset_txd", txd_v[s], 1);
        end

        run_frame(0, "lsb_a55a");
        run_frame(1, "msb_a55a");
        run_frame(2, "w12_pad");
        run_frame(3, "ignore_busy_load");

        // Reset in the middle of the first byte's data bits.
        sel = 0;
        din_v = 304'hA55A;
        load_v[0] = 1'b1;
        @(negedge clk);
        load_v = '0;
        repeat (29) @(negedge clk);
        check("pre_reset_busy", busy_m, 1);
        rstn = 1'b0;
        @(negedge clk);
        check("reset_mid_txd", txd_m, 1);
        check("reset_mid_busy", busy_m, 0);
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (done_m !== 1'b0 || busy_m !== 1'b0 || txd_m !== 1'b1) bad++;
            @(negedge clk);
        end
        check("after_abort_quiet_cycles", bad, 0);
        run_frame(0, "restart");

        run_frame(4, "big_first");
        run_frame(4, "big_back_to_back");

        // load held through the DONE cycle must only be taken once IDLE is reached.
        sel = 0;
        din_v = 304'hA55A;
        load_v[0] = 1'b1;
        @(negedge clk);
        load_v = '0;
        repeat (80) @(negedge clk);
        check("seq_done", done_m, 1);
        load_v[0] = 1'b1;
        @(negedge clk);
        check("load_in_done_ignored_busy", busy_m, 0);
        check("load_in_done_ignored_txd", txd_m, 1);
        @(negedge clk);
        load_v = '0;
        check("load_from_idle_busy", busy_m, 1);
        check("load_from_idle_txd", txd_m, 0);
        got = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done_m === 1'b1) begin
                got = i;
                break;
            end
        end
        check("reload_done_latency", got, 80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
